// File: rtl/tdm_multiplexer_if.sv
// Bus bundle between the 8-to-1 TDM multiplexer and its environment.
// With SKIP_MASK_EN defined the bundle also carries the per-frame channel mask.
interface tdm_multiplexer_if;
  logic       en;
  logic       din_0;
  logic       din_1;
  logic       din_2;
  logic       din_3;
  logic       din_4;
  logic       din_5;
  logic       din_6;
  logic       din_7;
  logic       dout;
  logic [2:0] sel;
  logic       vld;
  logic       frame_start;
`ifdef SKIP_MASK_EN
  logic [7:0] ch_mask;

  modport master (
    output en, din_0, din_1, din_2, din_3, din_4, din_5, din_6, din_7, ch_mask,
    input  dout, sel, vld, frame_start
  );
  modport slave (
    input  en, din_0, din_1, din_2, din_3, din_4, din_5, din_6, din_7, ch_mask,
    output dout, sel, vld, frame_start
  );
`else
  modport master (
    output en, din_0, din_1, din_2, din_3, din_4, din_5, din_6, din_7,
    input  dout, sel, vld, frame_start
  );
  modport slave (
    input  en, din_0, din_1, din_2, din_3, din_4, din_5, din_6, din_7,
    output dout, sel, vld, frame_start
  );
`endif
endinterface

// File: rtl/tdm_multiplexer.sv
// Round-robin 8-to-1 TDM multiplexer with per-slot dwell, slot index, valid and frame-start.
// Optional SKIP_MASK_EN adds a per-frame channel mask; masked channels take no slot time.
module tdm_multiplexer #(
  parameter int unsigned DWELL = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  tdm_multiplexer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] idx;
    logic       found;
    idx   = cur;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && (i > int'(cur)) && m[i]) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic any_above(input logic [7:0] m, input logic [2:0] cur);
    return (m >> ({1'b0, cur} + 4'd1)) != 8'd0;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       sel_q, sel_d;
  logic             dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             fs_q, fs_d;
  logic [7:0]       mask_q, mask_d;

  logic [7:0] din_vec;
  logic [7:0] new_mask;
  logic       start_ok;
  logic       slot_end;
  logic       wrap;

  assign din_vec = {bus.din_7, bus.din_6, bus.din_5, bus.din_4,
                    bus.din_3, bus.din_2, bus.din_1, bus.din_0};

`ifdef SKIP_MASK_EN
  assign new_mask = bus.ch_mask;
`else
  assign new_mask = 8'hFF;
`endif

  // mask_q holds the channel set latched at the current frame start
  assign start_ok = (new_mask != 8'd0);
  assign slot_end = (count_q == LAST_CNT);
  assign wrap     = slot_end && !any_above(mask_q, sel_q);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= {CNT_W{1'b0}};
      sel_q   <= 3'd0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      fs_q    <= 1'b0;
      mask_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      fs_q    <= fs_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state logic: a draining frame always ends at its last slot, even if en returns there
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.en && start_ok) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (wrap && !start_ok) begin
          state_d = IDLE;
        end else if (!bus.en) begin
          state_d = DRAIN;
        end else begin
          state_d = SCAN;
        end
      end
      DRAIN: begin
        if (wrap) begin
          state_d = IDLE;
        end else if (bus.en) begin
          state_d = SCAN;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and datapath logic: dout is taken from the channel sel moves to on the same edge
  always_comb begin
    count_d = count_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    fs_d    = 1'b0;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (state_d == SCAN) begin
          count_d = {CNT_W{1'b0}};
          sel_d   = lowest_set(new_mask);
          mask_d  = new_mask;
          fs_d    = 1'b1;
          vld_d   = 1'b1;
          dout_d  = din_vec[sel_d];
        end else begin
          count_d = {CNT_W{1'b0}};
          sel_d   = 3'd0;
          dout_d  = 1'b0;
          vld_d   = 1'b0;
        end
      end
      SCAN, DRAIN: begin
        if (state_d == IDLE) begin
          count_d = {CNT_W{1'b0}};
          sel_d   = 3'd0;
          dout_d  = 1'b0;
          vld_d   = 1'b0;
        end else begin
          if (slot_end) begin
            count_d = {CNT_W{1'b0}};
            if (wrap) begin
              sel_d  = lowest_set(new_mask);
              mask_d = new_mask;
              fs_d   = 1'b1;
            end else begin
              sel_d = next_set(mask_q, sel_q);
            end
          end else begin
            count_d = count_q + CNT_W'(1);
          end
          vld_d  = 1'b1;
          dout_d = din_vec[sel_d];
        end
      end
      default: begin
        count_d = {CNT_W{1'b0}};
        sel_d   = 3'd0;
        dout_d  = 1'b0;
        vld_d   = 1'b0;
      end
    endcase
  end

  assign bus.dout        = dout_q;
  assign bus.sel         = sel_q;
  assign bus.vld         = vld_q;
  assign bus.frame_start = fs_q;

endmodule

// File: doc/tdm_multiplexer.md
Name: tdm_multiplexer

Overview:
- Sequential 8-to-1 time-division multiplexer: the transmit-side counterpart of the 1-to-8 demultiplexer.
- Round-robin scans eight 1-bit input channels. Each channel is held for DWELL cycles.
- Presents the selected bit with its 3-bit slot index, a valid flag and a frame-start marker.
- Index, valid and frame-start are meant to drive the demultiplexer's sel/den on the far side.

Parameters:
- DWELL, 1, clock cycles per channel slot; legal range 1..255.
- CNT_W, 8, width of the internal dwell counter; must hold DWELL-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active low, sampled on rising clk.
- en  input  1  scan enable; level sensitive.
- din_0 .. din_7  input  1 each  channel data inputs.
- dout  output  1  registered selected channel bit.
- sel  output  3  registered index of the channel currently on dout.
- vld  output  1  high while dout/sel carry a live slot.
- frame_start  output  1  one-cycle pulse on the first cycle of slot 0 of each frame.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, dwell count=0, dout=0, sel=0, vld=0, frame_start=0. Reset has priority over every other event, including mid-frame; the frame is abandoned with no drain.
- FSM states and transitions:
  - IDLE: all outputs 0. If en=1 at an edge, go to SCAN. On that same edge: sel<=0, dout<=din_0, vld<=1, frame_start<=1, count<=0.
  - SCAN: on each edge, count increments while count<DWELL-1. At count==DWELL-1, count<=0 and sel<=sel+1; 7 wraps to 0.
  - If en=0 at an edge in SCAN, go to DRAIN; the scan continues unchanged.
  - DRAIN: scanning continues exactly as in SCAN.
    - en=1 at an edge in DRAIN returns to SCAN with no gap and no glitch on sel/dout.
    - When the last cycle of slot 7 completes with en=0, go to IDLE: vld<=0, dout<=0, sel<=0.
- Frames are never truncated by en; only reset truncates.
- Data path:
  - dout is registered every SCAN/DRAIN cycle from din[sel_next], where sel_next is the value sel takes on the same edge.
  - dout and sel always change together; latency from din to dout is one clock.
  - din may change inside a slot and dout follows, one clock later.
- frame_start is high for exactly one cycle, coinciding with the first cycle of sel=0: on IDLE->SCAN entry and on every 7->0 wrap that continues scanning.
- Simultaneous events:
  - en falling on the final cycle of slot 7 while in SCAN: the wrap to slot 0 still occurs (SCAN->DRAIN), and a full further frame follows.
  - en=1 on the same edge that leaves DRAIN for IDLE: go to IDLE; the next edge restarts the scan.
- DWELL=1: sel advances every cycle; count stays 0.

Optional Feature:
- Macro SKIP_MASK_EN.
- Defined:
  - Adds input ch_mask, 8 bits; bit i=1 enables channel i.
  - ch_mask is sampled at each frame start (IDLE->SCAN and each wrap). Its effect applies from that frame's first slot onward.
  - sel advances to the next enabled index, wrapping. Masked channels take no cycles.
  - frame_start marks the first slot of the lowest enabled index.
  - DRAIN ends after the highest enabled slot.
  - ch_mask=0 at entry: remain IDLE. ch_mask=0 at a wrap: go to IDLE.
- Undefined: no ch_mask port; all eight channels are scanned, as above.

Test Plan:
- Reset mid-frame: DWELL=1, en=1, reach sel=4, then drive rst_n=0 for 1 cycle -> next edge dout=0, sel=0, vld=0, frame_start=0, state IDLE.
- Basic scan: DWELL=1, din_0..din_7=1,0,1,1,0,0,1,0, en=1 constant -> sel 0..7 repeating one cycle each; dout 1,0,1,1,0,0,1,0; frame_start high every 8th cycle, aligned with sel=0; vld=1 throughout.
- Dwell: DWELL=3, en=1 -> each sel value held exactly 3 cycles; frame period 24 cycles; frame_start 1 cycle wide.
- Drain: DWELL=1, drop en while sel=2 -> scan continues through sel=7; vld falls the cycle after slot 7; dout=0, sel=0 thereafter.
- Drain cancel: DWELL=2, drop en at sel=3, raise en at sel=5 -> no gap; frame_start fires at the next wrap; vld never drops.
- With SKIP_MASK_EN: ch_mask=8'b1010_0100, DWELL=1 -> sel sequence 2,5,7,2,...; frame_start on sel=2. ch_mask=0 at entry -> vld stays 0.
